// File: rtl/egg_timer_ctrl.sv
// Egg timer sequencer: programs a seconds count, counts it down and sounds a timed alarm.
// Optional build macro TIMER_SNOOZE_EN: start_stop during the alarm reloads SNOOZE_SECS and restarts the run.
module egg_timer_ctrl #(
  parameter int SIZE        = 8,
  parameter int INC_STEP    = 10,
  parameter int MAX_SET     = 250,
  parameter int ALARM_SECS  = 30,
  parameter int SNOOZE_SECS = 60
) (
  input  logic            rst,
  input  logic            sec_clk,
  input  logic            inc,
  input  logic            start_stop,
  input  logic            clear,
  input  logic            ack,
  output logic [SIZE-1:0] remaining,
  output logic [2:0]      state,
  output logic            running,
  output logic            alarm,
  output logic            beep
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SET   = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] ALARM = 3'd4;

  localparam int CNT_W = $clog2(ALARM_SECS + 1);

  if (MAX_SET < INC_STEP || MAX_SET >= (2 ** SIZE) || ALARM_SECS < 1 ||
      SNOOZE_SECS >= (2 ** SIZE) || SNOOZE_SECS < 0) begin : g_bad_params
    $error("egg_timer_ctrl: illegal parameter combination");
  end

  // Add one increment step without wrapping, clamped at the programming ceiling.
  function automatic logic [SIZE-1:0] sat_add(input logic [SIZE-1:0] v);
    logic [SIZE:0] sum;
    sum = {1'b0, v} + (SIZE+1)'(INC_STEP);
    if (sum > (SIZE+1)'(MAX_SET))
      sat_add = SIZE'(MAX_SET);
    else
      sat_add = sum[SIZE-1:0];
  endfunction

  logic [CNT_W-1:0] alarm_cnt;
  logic [CNT_W-1:0] alarm_cnt_nxt;
  logic [2:0]       state_nxt;
  logic [SIZE-1:0]  rem_nxt;
  logic             beep_nxt;

  // Only the highest-priority pulse acts: clear > ack > start_stop > inc.
  logic do_clear, do_ack, do_ss, do_inc;
  assign do_clear = clear;
  assign do_ack   = ack & ~clear;
  assign do_ss    = start_stop & ~clear & ~ack;
  assign do_inc   = inc & ~clear & ~ack & ~start_stop;

  always_comb begin
    state_nxt     = state;
    rem_nxt       = remaining;
    beep_nxt      = 1'b0;
    alarm_cnt_nxt = '0;
    if (do_clear) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_inc) begin
            state_nxt = SET;
            rem_nxt   = SIZE'(INC_STEP);
          end
        end
        SET, PAUSE: begin
          if (do_ss)
            state_nxt = RUN;
          else if (do_inc)
            rem_nxt = sat_add(remaining);
        end
        RUN: begin
          if (do_ss) begin
            state_nxt = PAUSE;
          end else if (remaining <= SIZE'(1)) begin
            // Expiry lands in ALARM on the same edge the count reaches zero.
            state_nxt     = ALARM;
            rem_nxt       = '0;
            beep_nxt      = 1'b1;
            alarm_cnt_nxt = CNT_W'(1);
          end else begin
            rem_nxt = remaining - SIZE'(1);
          end
        end
        ALARM: begin
          if (do_ack) begin
            state_nxt = IDLE;
`ifdef TIMER_SNOOZE_EN
          end else if (do_ss) begin
            state_nxt = RUN;
            rem_nxt   = SIZE'(SNOOZE_SECS);
`endif
          end else if (alarm_cnt == CNT_W'(ALARM_SECS)) begin
            state_nxt = IDLE;
          end else begin
            beep_nxt      = ~beep;
            alarm_cnt_nxt = alarm_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sec_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      running   <= 1'b0;
      alarm     <= 1'b0;
      beep      <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      running   <= (state_nxt == RUN);
      alarm     <= (state_nxt == ALARM);
      beep      <= beep_nxt;
      alarm_cnt <= alarm_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: directed scenarios plus random pulses against a seconds-level reference model.
module tb_egg_timer_ctrl;

  logic       rst;
  logic       sec_clk = 1'b0;
  logic       inc = 1'b0, start_stop = 1'b0, clear = 1'b0, ack = 1'b0;
  logic [7:0] remaining;
  logic [2:0] state;
  logic       running, alarm, beep;

  egg_timer_ctrl dut (
    .rst(rst), .sec_clk(sec_clk), .inc(inc), .start_stop(start_stop),
    .clear(clear), .ack(ack), .remaining(remaining), .state(state),
    .running(running), .alarm(alarm), .beep(beep)
  );

  always #5 sec_clk = ~sec_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode name as small int, seconds left, seconds spent alarming.
  int m_st  = 0;
  int m_rem = 0;
  int m_age = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit i, input bit s, input bit c, input bit a);
    if (c) begin
      m_st = 0; m_rem = 0; m_age = 0;
    end else if (a) begin
      if (m_st == 4) begin m_st = 0; m_age = 0; end
      else if (m_st == 2) begin
        if (m_rem <= 1) begin m_rem = 0; m_st = 4; m_age = 1; end
        else m_rem = m_rem - 1;
      end
    end else begin
      case (m_st)
        0: if (!s && i) begin m_st = 1; m_rem = 10; end
        1, 3: begin
          if (s) m_st = 2;
          else if (i) m_rem = (m_rem + 10 > 250) ? 250 : m_rem + 10;
        end
        2: begin
          if (s) m_st = 3;
          else if (m_rem <= 1) begin m_rem = 0; m_st = 4; m_age = 1; end
          else m_rem = m_rem - 1;
        end
        default: begin
`ifdef TIMER_SNOOZE_EN
          if (s) begin m_st = 2; m_rem = 60; m_age = 0; end
          else
`endif
          if (m_age >= 30) begin m_st = 0; m_age = 0; end
          else m_age = m_age + 1;
        end
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"},     32'(state),     32'(m_st));
    chk({tag, ".remaining"}, 32'(remaining), 32'(m_rem));
    chk({tag, ".running"},   32'(running),   32'(m_st == 2));
    chk({tag, ".alarm"},     32'(alarm),     32'(m_st == 4));
    chk({tag, ".beep"},      32'(beep),      32'(m_st == 4 && (m_age % 2) == 1));
  endtask

  task automatic cycle(input bit i, input bit s, input bit c, input bit a, input string tag);
    @(negedge sec_clk);
    inc = i; start_stop = s; clear = c; ack = a;
    @(posedge sec_clk);
    model_step(i, s, c, a);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, tag);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge sec_clk);
    #1;
    check_outputs("reset");
    chk("reset.state_const", 32'(state), 32'd0);
    @(negedge sec_clk);
    rst = 1'b0;

    // Program 30 s and let it expire.
    cycle(1, 0, 0, 0, "inc1"); chk("inc1.rem", 32'(remaining), 32'd10);
    cycle(1, 0, 0, 0, "inc2"); chk("inc2.rem", 32'(remaining), 32'd20);
    cycle(1, 0, 0, 0, "inc3"); chk("inc3.rem", 32'(remaining), 32'd30);
    cycle(0, 1, 0, 0, "go");   chk("go.state", 32'(state), 32'd2);
    idle_cycles(29, "count");
    chk("count.rem1", 32'(remaining), 32'd1);
    cycle(0, 0, 0, 0, "expire");
    chk("expire.state", 32'(state), 32'd4);
    chk("expire.beep", 32'(beep), 32'd1);
    chk("expire.rem", 32'(remaining), 32'd0);
    cycle(0, 0, 0, 0, "alarm2"); chk("alarm2.beep", 32'(beep), 32'd0);
    idle_cycles(28, "alarm_run");
    chk("alarm_last.state", 32'(state), 32'd4);
    cycle(0, 0, 0, 0, "timeout"); chk("timeout.state", 32'(state), 32'd0);
    chk("timeout.alarm", 32'(alarm), 32'd0);

    // Saturation, pause and hold.
    for (int k = 0; k < 26; k++) cycle(1, 0, 0, 0, "sat_inc");
    chk("sat.rem", 32'(remaining), 32'd250);
    cycle(0, 1, 0, 0, "sat_go");
    idle_cycles(3, "sat_run");
    cycle(0, 1, 0, 0, "pause");
    chk("pause.rem", 32'(remaining), 32'd247);
    chk("pause.state", 32'(state), 32'd3);
    idle_cycles(5, "hold");
    chk("hold.rem", 32'(remaining), 32'd247);
    cycle(1, 0, 0, 0, "pause_inc"); chk("pause_inc.rem", 32'(remaining), 32'd250);
    cycle(0, 0, 1, 0, "clr");

    // Ack on the 4th alarm cycle.
    cycle(1, 0, 0, 0, "a_inc");
    cycle(0, 1, 0, 0, "a_go");
    idle_cycles(10, "a_cnt");
    chk("a_alarm.state", 32'(state), 32'd4);
    idle_cycles(2, "a_wait");
    cycle(0, 0, 0, 1, "a_ack"); chk("a_ack.state", 32'(state), 32'd0);

    // Simultaneous pulses.
    cycle(1, 0, 0, 0, "p_inc");
    cycle(0, 1, 0, 0, "p_go");
    cycle(0, 1, 1, 0, "clr_ss");
    chk("clr_ss.state", 32'(state), 32'd0);
    chk("clr_ss.rem", 32'(remaining), 32'd0);
    cycle(1, 0, 0, 0, "s_inc1");
    cycle(1, 0, 0, 0, "s_inc2");
    cycle(1, 1, 0, 0, "ss_inc");
    chk("ss_inc.state", 32'(state), 32'd2);
    chk("ss_inc.rem", 32'(remaining), 32'd20);

    // start_stop while alarming.
    idle_cycles(20, "z_run");
    chk("z_alarm.state", 32'(state), 32'd4);
    cycle(0, 1, 0, 0, "snooze");
`ifdef TIMER_SNOOZE_EN
    chk("snooze.state", 32'(state), 32'd2);
    chk("snooze.rem", 32'(remaining), 32'd60);
`else
    chk("snooze.state", 32'(state), 32'd4);
    chk("snooze.beep", 32'(beep), 32'd0);
`endif
    idle_cycles(3, "after_snooze");
    cycle(0, 0, 1, 0, "z_clr");

    // Asynchronous reset mid-run at 37 s.
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, "r_inc");
    cycle(0, 1, 0, 0, "r_go");
    idle_cycles(3, "r_run");
    chk("r_run.rem", 32'(remaining), 32'd37);
    #2;
    rst = 1'b1;
    #1;
    m_st = 0; m_rem = 0; m_age = 0;
    check_outputs("async_rst");
    chk("async_rst.rem", 32'(remaining), 32'd0);
    @(negedge sec_clk);
    rst = 1'b0;

    // Random pulse traffic.
    for (int k = 0; k < 4000; k++) begin
      cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
            $urandom_range(0, 199) < 2, $urandom_range(0, 99) < 5, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
